// File: rtl/jtframe_joy_pkg.sv
// Shared step numbers, joy word layout and per-port capture rules for the MC2 DB9 scanner.
// Six-button detection and X/Y/Z/Mode capture are enabled by defining JTFRAME_JOY_SIX_EN.
package jtframe_joy_pkg;

`ifdef JTFRAME_JOY_SIX_EN
  localparam bit SIX_EN = 1'b1;
`else
  localparam bit SIX_EN = 1'b0;
`endif

  localparam logic [3:0] STEP_DIR    = 4'd1;
  localparam logic [3:0] STEP_AST    = 4'd2;
  localparam logic [3:0] STEP_SIXDET = 4'd4;
  localparam logic [3:0] STEP_XYZ    = 4'd5;
  localparam logic [3:0] STEP_PUB    = 4'd7;

  localparam int JB_UP    = 0;
  localparam int JB_DOWN  = 1;
  localparam int JB_LEFT  = 2;
  localparam int JB_RIGHT = 3;
  localparam int JB_B     = 4;
  localparam int JB_C     = 5;
  localparam int JB_A     = 6;
  localparam int JB_START = 7;
  localparam int JB_Z     = 8;
  localparam int JB_Y     = 9;
  localparam int JB_X     = 10;
  localparam int JB_MODE  = 11;

  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  typedef logic [11:0] joy_word_t;

  localparam joy_word_t XYZ_MASK = joy_word_t'((1 << JB_Z) | (1 << JB_Y) | (1 << JB_X) | (1 << JB_MODE));

  // Shadow keeps buttons active-low, exactly as sampled from the pins.
  typedef struct packed {
    joy_word_t btn_n;
    logic      md;
    logic      six;
  } joy_shadow_t;

  localparam joy_shadow_t SHADOW_RST = '{btn_n: 12'hFFF, md: 1'b0, six: 1'b0};

  function automatic logic step_sel(input logic [3:0] step);
    return step[3] | step[0];
  endfunction

  function automatic joy_shadow_t joy_capture(input joy_shadow_t sh, input logic [3:0] step,
                                              input logic [5:0] pins);
    joy_shadow_t r;
    r = sh;
    case (step)
      STEP_DIR: begin
        r.btn_n[JB_UP]    = pins[PIN_UP];
        r.btn_n[JB_DOWN]  = pins[PIN_DOWN];
        r.btn_n[JB_LEFT]  = pins[PIN_LEFT];
        r.btn_n[JB_RIGHT] = pins[PIN_RIGHT];
        r.btn_n[JB_B]     = pins[PIN_P6];
        r.btn_n[JB_C]     = pins[PIN_P9];
      end
      STEP_AST: begin
        r.md              = ~pins[PIN_LEFT] & ~pins[PIN_RIGHT];
        r.btn_n[JB_A]     = r.md ? pins[PIN_P6] : 1'b1;
        r.btn_n[JB_START] = r.md ? pins[PIN_P9] : 1'b1;
      end
      STEP_SIXDET: r.six = SIX_EN & (pins[3:0] == 4'b0000);
      STEP_XYZ: begin
        r.btn_n[JB_Z]    = (SIX_EN & sh.six) ? pins[PIN_UP]    : 1'b1;
        r.btn_n[JB_Y]    = (SIX_EN & sh.six) ? pins[PIN_DOWN]  : 1'b1;
        r.btn_n[JB_X]    = (SIX_EN & sh.six) ? pins[PIN_LEFT]  : 1'b1;
        r.btn_n[JB_MODE] = (SIX_EN & sh.six) ? pins[PIN_RIGHT] : 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic joy_word_t joy_publish(input joy_shadow_t sh);
    joy_word_t w;
    w = ~sh.btn_n;
    if (!SIX_EN) w = w & ~XYZ_MASK;
    return w;
  endfunction

endpackage

// File: rtl/jtframe_joy_tick.sv
// Step-rate divider: one-cycle tick every TICK_N clocks, first tick TICK_N cycles after reset.
module jtframe_joy_tick #(
  parameter int TICK_N = 1
) (
  input  logic clk_sys,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? RELOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jtframe_mc2_joyscan.sv
// Multicore 2 DB9 scan controller: 16-step select sequence per frame, MS/MD3/MD6 detection,
// frame-atomic active-high button words. Build macro: JTFRAME_JOY_SIX_EN.
module jtframe_mc2_joyscan #(
  parameter int CLK_KHZ = 25000,
  parameter int HALF_US = 9
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [5:0]  joy1_pins,
  input  logic [5:0]  joy2_pins,
  output logic        joy_sel,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic        six1,
  output logic        six2,
  output logic        md1,
  output logic        md2,
  output logic        frame_valid
);
  import jtframe_joy_pkg::*;

  localparam int TICK_RAW = CLK_KHZ * HALF_US / 1000;
  localparam int TICK_N   = (TICK_RAW < 1) ? 1 : TICK_RAW;

  logic        tick;
  logic [3:0]  step_q, step_d;
  logic        sel_q, sel_d;
  joy_shadow_t sh1_q, sh1_d, sh2_q, sh2_d;
  joy_word_t   joy1_q, joy1_d, joy2_q, joy2_d;
  logic        md1_q, md1_d, md2_q, md2_d;
  logic        six1_q, six1_d, six2_q, six2_d;
  logic        fv_q, fv_d;

  jtframe_joy_tick #(.TICK_N(TICK_N)) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .tick    (tick)
  );

  // Sampling uses the step that is ending, so pins have been stable for a whole step.
  always_comb begin
    step_d = step_q;
    sel_d  = step_sel(step_q);
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    joy1_d = joy1_q;
    joy2_d = joy2_q;
    md1_d  = md1_q;
    md2_d  = md2_q;
    six1_d = six1_q;
    six2_d = six2_q;
    fv_d   = 1'b0;
    if (tick) begin
      step_d = step_q + 4'd1;
      sh1_d  = joy_capture(sh1_q, step_q, joy1_pins);
      sh2_d  = joy_capture(sh2_q, step_q, joy2_pins);
      if (step_q == STEP_PUB) begin
        joy1_d = joy_publish(sh1_q);
        joy2_d = joy_publish(sh2_q);
        md1_d  = sh1_q.md;
        md2_d  = sh2_q.md;
        six1_d = SIX_EN & sh1_q.six;
        six2_d = SIX_EN & sh2_q.six;
        fv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      step_q <= 4'd0;
      sel_q  <= 1'b1;
      sh1_q  <= SHADOW_RST;
      sh2_q  <= SHADOW_RST;
      joy1_q <= '0;
      joy2_q <= '0;
      md1_q  <= 1'b0;
      md2_q  <= 1'b0;
      six1_q <= 1'b0;
      six2_q <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      step_q <= step_d;
      sel_q  <= sel_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      joy1_q <= joy1_d;
      joy2_q <= joy2_d;
      md1_q  <= md1_d;
      md2_q  <= md2_d;
      six1_q <= six1_d;
      six2_q <= six2_d;
      fv_q   <= fv_d;
    end
  end

  assign joy_sel     = sel_q;
  assign joy1        = joy1_q;
  assign joy2        = joy2_q;
  assign md1         = md1_q;
  assign md2         = md2_q;
  assign six1        = six1_q;
  assign six2        = six2_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_jtframe_mc2_joyscan.sv
// Bench for jtframe_mc2_joyscan: behavioural SMS/MD3/MD6 pad models driven by joy_sel,
// table vectors, reset/latency sequences and random pads checked against a button-level model.
module tb_jtframe_mc2_joyscan;

  localparam int PAD_SMS = 0;
  localparam int PAD_MD  = 1;
  localparam int PAD_SIX = 2;

`ifdef JTFRAME_JOY_SIX_EN
  localparam bit SIX_EN = 1'b1;
`else
  localparam bit SIX_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  t1;
    logic [11:0] b1;
    logic [1:0]  t2;
    logic [11:0] b2;
    logic [11:0] e1;
    logic [11:0] e2;
    logic        md1;
    logic        md2;
    logic        six1;
    logic        six2;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  joy1_pins, joy2_pins;
  logic        joy_sel;
  logic [11:0] joy1, joy2;
  logic        six1, six2, md1, md2, frame_valid;

  int          pad1_type = PAD_SMS;
  int          pad2_type = PAD_SMS;
  logic [11:0] pad1_btn = 12'h000;
  logic [11:0] pad2_btn = 12'h000;
  int          pad_cnt = 0;
  int          idle_cnt = 0;
  logic        prev_sel = 1'b1;

  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[6];

  jtframe_mc2_joyscan #(.CLK_KHZ(1000), .HALF_US(4)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .joy1_pins   (joy1_pins),
    .joy2_pins   (joy2_pins),
    .joy_sel     (joy_sel),
    .joy1        (joy1),
    .joy2        (joy2),
    .six1        (six1),
    .six2        (six2),
    .md1         (md1),
    .md2         (md2),
    .frame_valid (frame_valid)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad-side phase counter: counts select falling edges, cleared after a long select-high idle.
  always @(posedge clk_sys) begin
    if (joy_sel === 1'b0) idle_cnt <= 0;
    else if (idle_cnt < 1000) idle_cnt <= idle_cnt + 1;
    if (prev_sel === 1'b1 && joy_sel === 1'b0) pad_cnt <= pad_cnt + 1;
    else if (idle_cnt > 12) pad_cnt <= 0;
    prev_sel <= joy_sel;
  end

  function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b, input logic sel,
                                          input int cnt);
    logic [5:0] p;
    if (t == PAD_SMS || sel) begin
      if (t == PAD_SIX && cnt == 3) p = {b[5], b[4], b[11], b[10], b[9], b[8]};
      else                          p = {b[5], b[4], b[3], b[2], b[1], b[0]};
    end else begin
      if (t == PAD_SIX && cnt == 3) p = {b[7], b[6], 4'b1111};
      else                          p = {b[7], b[6], 2'b11, b[1], b[0]};
    end
    return ~p;
  endfunction

  always_comb joy1_pins = pad_pins(pad1_type, pad1_btn, joy_sel, pad_cnt);
  always_comb joy2_pins = pad_pins(pad2_type, pad2_btn, joy_sel, pad_cnt);

  // Button-level reference: which button groups a pad type can report.
  function automatic logic [13:0] model(input int t, input logic [11:0] b);
    logic [11:0] w;
    logic        md, six;
    w   = b & 12'h03F;
    md  = (t != PAD_SMS);
    six = (t == PAD_SIX) && SIX_EN;
    if (md)  w = w | (b & 12'h0C0);
    if (six) w = w | (b & 12'hF00);
    return {six, md, w};
  endfunction

  function automatic logic exp_sel(input int n);
    int s;
    s = ((n - 1) / 4) % 16;
    return !(s < 8 && (s % 2) == 0);
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    int v, h;
    b = 12'($urandom) & 12'hFF0;
    v = $urandom_range(0, 2);
    h = $urandom_range(0, 2);
    if (v == 1) b[0] = 1'b1; else if (v == 2) b[1] = 1'b1;
    if (h == 1) b[2] = 1'b1; else if (h == 2) b[3] = 1'b1;
    return b;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int t1, input logic [11:0] b1, input int t2,
                               input logic [11:0] b2);
    pad1_type = t1;
    pad1_btn  = b1;
    pad2_type = t2;
    pad2_btn  = b2;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] e1, input logic [11:0] e2,
                             input logic em1, input logic em2, input logic es1, input logic es2);
    check_val({name, "/joy1"}, 32'(joy1), 32'(e1));
    check_val({name, "/joy2"}, 32'(joy2), 32'(e2));
    check_val({name, "/md1"},  32'(md1),  32'(em1));
    check_val({name, "/md2"},  32'(md2),  32'(em2));
    check_val({name, "/six1"}, 32'(six1), 32'(es1));
    check_val({name, "/six2"}, 32'(six2), 32'(es2));
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk_sys);
      if (frame_valid === 1'b1) seen = 1'b1;
    end
    check_val({name, "/frame_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int bad, sel_bad, hold, r;
    bit seen;

    vecs[0] = '{t1: 2'd0, b1: 12'h000, t2: 2'd0, b2: 12'h000, e1: 12'h000, e2: 12'h000,
                md1: 1'b0, md2: 1'b0, six1: 1'b0, six2: 1'b0};
    vecs[1] = '{t1: 2'd1, b1: 12'h0C0, t2: 2'd0, b2: 12'h000, e1: 12'h0C0, e2: 12'h000,
                md1: 1'b1, md2: 1'b0, six1: 1'b0, six2: 1'b0};
    vecs[2] = '{t1: 2'd0, b1: 12'h000, t2: 2'd2, b2: 12'h400, e1: 12'h000,
                e2: SIX_EN ? 12'h400 : 12'h000, md1: 1'b0, md2: 1'b1, six1: 1'b0, six2: SIX_EN};
    vecs[3] = '{t1: 2'd0, b1: 12'h018, t2: 2'd0, b2: 12'h000, e1: 12'h018, e2: 12'h000,
                md1: 1'b0, md2: 1'b0, six1: 1'b0, six2: 1'b0};
    vecs[4] = '{t1: 2'd2, b1: 12'hFF9, t2: 2'd1, b2: 12'h022,
                e1: SIX_EN ? 12'hFF9 : 12'h0F9, e2: 12'h022,
                md1: 1'b1, md2: 1'b1, six1: SIX_EN, six2: 1'b0};
    vecs[5] = '{t1: 2'd1, b1: 12'h401, t2: 2'd0, b2: 12'h0E4, e1: 12'h001, e2: 12'h024,
                md1: 1'b1, md2: 1'b0, six1: 1'b0, six2: 1'b0};

    // Reset state and cycle-exact select / first publish timing with idle ports.
    applyStimulus(PAD_SMS, 12'h000, PAD_SMS, 12'h000);
    rst = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_val("rst_sel", 32'(joy_sel), 32'd1);
    check_val("rst_fv", 32'(frame_valid), 32'd0);
    checkOutput("rst", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk_sys);
      check_val($sformatf("sel_c%0d", n), 32'(joy_sel), 32'(exp_sel(n)));
      check_val($sformatf("fv_c%0d", n), 32'(frame_valid), 32'(n == 32));
      if (n == 32) checkOutput("idle_frame", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    wait_frame("sync");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(int'(vecs[i].t1), vecs[i].b1, int'(vecs[i].t2), vecs[i].b2);
      wait_frame($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].md1, vecs[i].md2,
                  vecs[i].six1, vecs[i].six2);
    end

    // One-cycle reset during step 5 of a frame with pressed inputs.
    applyStimulus(PAD_MD, 12'h0C0, PAD_SMS, 12'h000);
    wait_frame("pre_rst");
    checkOutput("pre_rst", 12'h0C0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (52) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
    check_val("midrst_sel", 32'(joy_sel), 32'd1);
    check_val("midrst_fv", 32'(frame_valid), 32'd0);
    checkOutput("midrst", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk_sys);
      if (frame_valid !== (n == 32)) bad++;
    end
    check_val("midrst_fv_timing", 32'(bad), 32'd0);
    checkOutput("midrst_pub", 12'h0C0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Up held for exactly one frame must read back for exactly one frame period.
    applyStimulus(PAD_SMS, 12'h000, PAD_SMS, 12'h000);
    wait_frame("t6_clear");
    applyStimulus(PAD_SMS, 12'h001, PAD_SMS, 12'h000);
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk_sys);
      if (frame_valid === 1'b1) seen = 1'b1;
      else if (joy1 !== 12'h000) bad++;
    end
    check_val("t6_fv_seen", 32'(seen), 32'd1);
    check_val("t6_early_change", 32'(bad), 32'd0);
    check_val("t6_pub", 32'(joy1), 32'h001);
    applyStimulus(PAD_SMS, 12'h000, PAD_SMS, 12'h000);
    hold = 1;
    sel_bad = 0;
    r = 0;
    while (joy1 === 12'h001 && r < 200) begin
      @(negedge clk_sys);
      r++;
      if (joy_sel !== exp_sel(32 + r)) sel_bad++;
      if (joy1 === 12'h001) hold++;
    end
    check_val("t6_hold", 32'(hold), 32'd64);
    check_val("t6_sel_wrap", 32'(sel_bad), 32'd0);
    check_val("t6_fv_at_change", 32'(frame_valid), 32'd1);
    check_val("t6_cleared", 32'(joy1), 32'h000);

    // Random pads and buttons, one frame each.
    for (int k = 0; k < 40; k++) begin
      int t1, t2;
      logic [11:0] b1, b2;
      logic [13:0] m1, m2;
      t1 = $urandom_range(0, 2);
      t2 = $urandom_range(0, 2);
      b1 = rand_btn();
      b2 = rand_btn();
      m1 = model(t1, b1);
      m2 = model(t2, b2);
      applyStimulus(t1, b1, t2, b2);
      wait_frame($sformatf("rnd%0d", k));
      checkOutput($sformatf("rnd%0d", k), m1[11:0], m2[11:0], m1[12], m2[12], m1[13], m2[13]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
